// File: rtl/posit_dot_sched_pkg.sv
// Shared types and constants for the posit dot-product scheduler.
package posit_dot_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        RESP
    } sched_state_t;

    localparam logic [31:0] POSIT_NAR = 32'h8000_0000;

endpackage

// File: rtl/posit_dot_sched_arb.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module posit_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic update_i,
    input  logic served_i,
    output logic grant_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = ~served_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        grant_o = ptr_q;
        if (valid0_i && !valid1_i) begin
            grant_o = 1'b0;
        end else if (valid1_i && !valid0_i) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/posit_dot_sched.sv
// Shares one pipelined posit MAC between two requesters, one whole job at a time,
// and returns each accumulated result (or NaR on timeout) to the job owner.
module posit_dot_sched
    import posit_dot_sched_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int LAT   = 6,
    parameter int SLACK = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [NBITS-1:0] req0_a,
    input  logic [NBITS-1:0] req0_b,
    input  logic             req0_last,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [NBITS-1:0] req1_a,
    input  logic [NBITS-1:0] req1_b,
    input  logic             req1_last,
    output logic             mac_valid,
    output logic [NBITS-1:0] mac_a,
    output logic [NBITS-1:0] mac_b,
    output logic             mac_first,
    output logic             mac_last,
    input  logic             mac_result_valid,
    input  logic [NBITS-1:0] mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_result,
    output logic             out_id,
    output logic [CNTW-1:0]  out_count,
    output logic             err_timeout,
    output logic             err_spurious
);

    localparam int DW = $clog2(LAT + SLACK + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(LAT + SLACK);
    localparam logic [NBITS-1:0] NAR = {POSIT_NAR[31], {(NBITS-1){1'b0}}};

    sched_state_t     state_q, state_d;
    logic             grant_q, grant_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             mac_valid_q, mac_valid_d;
    logic [NBITS-1:0] mac_a_q, mac_a_d;
    logic [NBITS-1:0] mac_b_q, mac_b_d;
    logic             mac_first_q, mac_first_d;
    logic             mac_last_q, mac_last_d;
    logic [NBITS-1:0] out_result_q, out_result_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_spurious_q, err_spurious_d;

    logic             arb_grant;
    logic             sel_valid;
    logic             sel_last;
    logic [NBITS-1:0] sel_a;
    logic [NBITS-1:0] sel_b;
    logic             beat_hs;
    logic             resp_done;

    posit_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .update_i (resp_done),
        .served_i (grant_q),
        .grant_o  (arb_grant)
    );

    assign sel_valid  = grant_q ? req1_valid : req0_valid;
    assign sel_last   = grant_q ? req1_last  : req0_last;
    assign sel_a      = grant_q ? req1_a     : req0_a;
    assign sel_b      = grant_q ? req1_b     : req0_b;
    assign req0_ready = (state_q == STREAM) && !grant_q;
    assign req1_ready = (state_q == STREAM) && grant_q;
    assign beat_hs    = (state_q == STREAM) && sel_valid;
    assign resp_done  = (state_q == RESP) && out_ready;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        count_d        = count_q;
        drain_d        = drain_q;
        mac_valid_d    = 1'b0;
        mac_a_d        = mac_a_q;
        mac_b_d        = mac_b_q;
        mac_first_d    = 1'b0;
        mac_last_d     = 1'b0;
        out_result_d   = out_result_q;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q | (mac_result_valid && (state_q != DRAIN));
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = arb_grant;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (beat_hs) begin
                    mac_valid_d = 1'b1;
                    mac_a_d     = sel_a;
                    mac_b_d     = sel_b;
                    mac_first_d = (count_q == '0);
                    mac_last_d  = sel_last;
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    // The drain window opens in the same cycle mac_last reaches the MAC.
                    if (sel_last) begin
                        drain_d = DRAIN_LOAD;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (mac_result_valid) begin
                    out_result_d = mac_result;
                    state_d      = RESP;
                end else if (drain_q == '0) begin
                    out_result_d  = NAR;
                    err_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_q        <= 1'b0;
            count_q        <= '0;
            drain_q        <= '0;
            mac_valid_q    <= 1'b0;
            mac_a_q        <= '0;
            mac_b_q        <= '0;
            mac_first_q    <= 1'b0;
            mac_last_q     <= 1'b0;
            out_result_q   <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            count_q        <= count_d;
            drain_q        <= drain_d;
            mac_valid_q    <= mac_valid_d;
            mac_a_q        <= mac_a_d;
            mac_b_q        <= mac_b_d;
            mac_first_q    <= mac_first_d;
            mac_last_q     <= mac_last_d;
            out_result_q   <= out_result_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign mac_valid    = mac_valid_q;
    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;
    assign mac_first    = mac_first_q;
    assign mac_last     = mac_last_q;
    assign out_valid    = (state_q == RESP);
    assign out_result   = out_result_q;
    assign out_id       = grant_q;
    assign out_count    = count_q;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;

endmodule
